// File: rtl/config_pkg.sv
// Shared FMA configuration: default widths and per-format constants, so the
// shift-control pipe and the postprocessor agree on bias and fraction sizes.
package config_pkg;

    function automatic int sw_of(input int fmalen);
        return $clog2(fmalen + 1);
    endfunction

    function automatic int fw_of(input int nfmt);
        return (nfmt > 1) ? $clog2(nfmt) : 1;
    endfunction

    localparam int CFG_NE     = 11;
    localparam int CFG_NF     = 52;
    localparam int CFG_FMALEN = 3 * CFG_NF + 6;
    localparam int CFG_NFMT   = 2;
    localparam int CFG_STAGES = 2;
    localparam int CFG_SW     = sw_of(CFG_FMALEN);
    localparam int CFG_FW     = fw_of(CFG_NFMT);

    // Index 0 is the widest format: double, single, half, bfloat16.
    localparam int FMT_BIAS [0:3] = '{1023, 127, 15, 127};
    localparam int FMT_NF   [0:3] = '{52, 23, 10, 7};

endpackage

// File: rtl/fma_pipe_reg.sv
// One elastic register slice: a valid bit plus a data word.
// Handshake: a slice takes in_valid/in_data on any edge where advance is high;
// advance is driven by the owner as ~valid | downstream-advance.
module fma_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         advance,
    input  logic [W-1:0] in_data,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (advance)
                valid <= in_valid;
            // Data only moves with a real entry so a stalled output never glitches.
            if (advance && in_valid)
                data <= in_data;
        end
    end

endmodule

// File: rtl/fma_norm_ctl_pipe.sv
// FMA post-processing shift control: normalized exponent, zero/subnormal
// flags and normalization shift amount, behind 1..3 elastic register stages.
module fma_norm_ctl_pipe
    import config_pkg::*;
#(
    parameter int NE     = CFG_NE,
    parameter int NF     = CFG_NF,
    parameter int FMALEN = CFG_FMALEN,
    parameter int NFMT   = CFG_NFMT,
    parameter int STAGES = CFG_STAGES,
    parameter int SW     = sw_of(FMALEN),
    parameter int FW     = fw_of(NFMT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [FW-1:0]     FmtIdx,
    input  logic [NE+1:0]     FmaSe,
    input  logic [FMALEN-1:0] FmaSm,
    input  logic [SW-1:0]     FmaSCnt,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [NE+1:0]     NormSumExp,
    output logic              FmaSZero,
    output logic              FmaPreResultSubnorm,
    output logic [SW-1:0]     FmaShiftAmt,
    output logic              FmtErr
);

    localparam int EW = NE + 2;
    localparam int W1 = 2 * EW + 1 + FW + 2 * SW;
    localparam int WF = EW + 2 + SW;

    function automatic logic [EW-1:0] bias_corr(input logic [FW-1:0] k);
        return EW'(FMT_BIAS[k] - FMT_BIAS[0]);
    endfunction

    // Second half of the datapath: signed window compares and shift select.
    function automatic logic [WF-1:0] finish_calc(input logic [W1-1:0] s);
        logic [EW-1:0] p, bc, hi, lo;
        logic          z, sub;
        logic [FW-1:0] k;
        logic [SW-1:0] se_lo, scnt, sh;
        {p, bc, z, k, se_lo, scnt} = s;
        hi  = EW'(FMT_BIAS[0] - FMT_BIAS[k]);
        lo  = EW'(FMT_BIAS[0] - FMT_BIAS[k] - FMT_NF[k] - 1);
        sub = ($signed(p) <= $signed(hi)) & (($signed(p) >= $signed(lo)) | (p == '0));
        sh  = sub ? (se_lo + SW'(NF + 3) + bc[SW-1:0]) : (scnt + SW'(1));
        return {p + bc, z, sub, sh};
    endfunction

    logic          illegal_fmt;
    logic [FW-1:0] k_in;
    logic [EW-1:0] p_in;
    logic [W1-1:0] s1_in;

    assign illegal_fmt = (int'(FmtIdx) >= NFMT);
    assign k_in        = illegal_fmt ? '0 : FmtIdx;
    assign p_in        = FmaSe - EW'(FmaSCnt) + EW'(NF + 3);
    assign s1_in       = {p_in, bias_corr(k_in), ~|FmaSm, k_in, FmaSe[SW-1:0], FmaSCnt};

    logic [STAGES-1:0] vld;
    logic [STAGES:0]   go;
    logic [WF-1:0]     out_q;

    assign go[STAGES] = OutReady;
    for (genvar i = 0; i < STAGES; i++) begin : g_go
        assign go[i] = ~vld[i] | go[i+1];
    end

    if (STAGES == 1) begin : g_one
        logic [WF-1:0] fin_in;
        assign fin_in = finish_calc(s1_in);
        fma_pipe_reg #(.W(WF)) u_r0 (
            .clk(clk), .reset(reset), .flush(Flush), .in_valid(InValid), .advance(go[0]),
            .in_data(fin_in), .valid(vld[0]), .data(out_q)
        );
    end else begin : g_multi
        logic [W1-1:0] mid [0:STAGES-2];
        logic [WF-1:0] fin_in;

        fma_pipe_reg #(.W(W1)) u_r0 (
            .clk(clk), .reset(reset), .flush(Flush), .in_valid(InValid), .advance(go[0]),
            .in_data(s1_in), .valid(vld[0]), .data(mid[0])
        );
        if (STAGES == 3) begin : g_pass
            fma_pipe_reg #(.W(W1)) u_r1 (
                .clk(clk), .reset(reset), .flush(Flush), .in_valid(vld[0]), .advance(go[1]),
                .in_data(mid[0]), .valid(vld[1]), .data(mid[1])
            );
        end
        assign fin_in = finish_calc(mid[STAGES-2]);
        fma_pipe_reg #(.W(WF)) u_rl (
            .clk(clk), .reset(reset), .flush(Flush), .in_valid(vld[STAGES-2]),
            .advance(go[STAGES-1]), .in_data(fin_in), .valid(vld[STAGES-1]), .data(out_q)
        );
    end

    // Gating with reset keeps any handshake from completing in a reset cycle.
    assign InReady  = go[0] & ~reset;
    assign OutValid = vld[STAGES-1] & ~reset;
    assign {NormSumExp, FmaSZero, FmaPreResultSubnorm, FmaShiftAmt} = out_q;

    always_ff @(posedge clk) begin
        if (reset)
            FmtErr <= 1'b0;
        else if (InValid && InReady && illegal_fmt)
            FmtErr <= 1'b1;
    end

endmodule
